// File: rtl/controlador_pkg.sv
// controlador_pkg
// Shared definitions for the parametrised parking access controller:
//   - 3-bit state encodings and the enum built on them
//   - default parameter values for the controller and its PIN timer
//   - the gate/alarm output bundle and its per-state decode
//   - a constant clog2 helper used to size counters
// No ports; imported by controlador_acceso_param and temporizador_pin.
package controlador_pkg;

  localparam logic [2:0] ST_IDLE       = 3'd0;
  localparam logic [2:0] ST_ESPERA_PIN = 3'd1;
  localparam logic [2:0] ST_ABIERTO    = 3'd2;
  localparam logic [2:0] ST_ALARMA     = 3'd3;
  localparam logic [2:0] ST_BLOQUEO    = 3'd4;

  typedef enum logic [2:0] {
    IDLE       = ST_IDLE,
    ESPERA_PIN = ST_ESPERA_PIN,
    ABIERTO    = ST_ABIERTO,
    ALARMA     = ST_ALARMA,
    BLOQUEO    = ST_BLOQUEO
  } estado_t;

  localparam int         DEF_PIN_W        = 8;
  localparam logic [7:0] DEF_PIN_CORRECTO = 8'h2A;
  localparam int         DEF_MAX_INTENTOS = 3;
  localparam int         DEF_TIMEOUT      = 16;
  localparam int         DEF_CNT_W        = 8;

  typedef struct packed {
    logic cerrado;
    logic abierto;
    logic alarma;
    logic bloqueo;
  } salidas_t;

  // Smallest n with 2**n >= valor; valor is always >= 2 here.
  function automatic int clog2(input int valor);
    int res;
    res = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < valor) begin
        res = i + 1;
      end
    end
    return res;
  endfunction

  // Moore decode; unknown encodings fall back to the closed/idle pattern.
  function automatic salidas_t decodificar(input estado_t estado);
    salidas_t s;
    s = '{cerrado: 1'b1, abierto: 1'b0, alarma: 1'b0, bloqueo: 1'b0};
    case (estado)
      IDLE:       s = '{cerrado: 1'b1, abierto: 1'b0, alarma: 1'b0, bloqueo: 1'b0};
      ESPERA_PIN: s = '{cerrado: 1'b1, abierto: 1'b0, alarma: 1'b0, bloqueo: 1'b0};
      ABIERTO:    s = '{cerrado: 1'b0, abierto: 1'b1, alarma: 1'b0, bloqueo: 1'b0};
      ALARMA:     s = '{cerrado: 1'b1, abierto: 1'b0, alarma: 1'b1, bloqueo: 1'b0};
      BLOQUEO:    s = '{cerrado: 1'b1, abierto: 1'b0, alarma: 1'b1, bloqueo: 1'b1};
      default:    s = '{cerrado: 1'b1, abierto: 1'b0, alarma: 1'b0, bloqueo: 1'b0};
    endcase
    return s;
  endfunction

endpackage

// File: rtl/temporizador_pin.sv
// temporizador_pin
// PIN-entry session timer. Counts enabled cycles and pulses expira on the
// cycle whose edge would bring the count to TIMEOUT; the count then restarts
// from zero so a session kept alive by the vehicle sensor gets a fresh period.
// Ports:
//   Clk    in  clock, rising edge
//   Reset  in  synchronous, active-high
//   clr    in  clear the count (has priority over en)
//   en     in  count this cycle
//   expira out combinational terminal-count pulse
module temporizador_pin
  import controlador_pkg::*;
#(
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic Clk,
  input  logic Reset,
  input  logic clr,
  input  logic en,
  output logic expira
);

  localparam int            TW     = clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] ULTIMO = TW'(TIMEOUT - 1);

  logic [TW-1:0] cuenta_q;
  logic [TW-1:0] cuenta_d;

  always_comb begin
    expira   = en && !clr && (cuenta_q == ULTIMO);
    cuenta_d = cuenta_q;
    if (clr || expira) begin
      cuenta_d = '0;
    end else if (en) begin
      cuenta_d = cuenta_q + TW'(1);
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      cuenta_q <= '0;
    end else begin
      cuenta_q <= cuenta_d;
    end
  end

endmodule

// File: rtl/controlador_acceso_param.sv
// controlador_acceso_param
// Single-gate parking access controller. Senses an arriving vehicle, checks
// strobed PIN words, opens the gate on the correct PIN, raises an alarm after
// MAX_INTENTOS wrong PINs, blocks the gate on tailgating, abandons idle PIN
// sessions after TIMEOUT cycles and counts vehicles that have passed.
// Ports:
//   Clk               in  clock, rising edge
//   Reset             in  synchronous, active-high
//   Vehiculo          in  entry sensor
//   Termino           in  exit sensor
//   Pin[PIN_W]        in  PIN word, valid with Pin_valido
//   Pin_valido        in  one-cycle PIN strobe
//   Cerrado           out gate closed command
//   Abierto           out gate open command
//   Alarma            out alarm indicator
//   Bloqueo           out tailgate block indicator
//   Intentos          out wrong-attempt count, saturates at MAX_INTENTOS
//   Conteo_vehiculos  out vehicles passed, wraps
module controlador_acceso_param
  import controlador_pkg::*;
#(
  parameter int               PIN_W        = DEF_PIN_W,
  parameter logic [PIN_W-1:0] PIN_CORRECTO = PIN_W'(DEF_PIN_CORRECTO),
  parameter int               MAX_INTENTOS = DEF_MAX_INTENTOS,
  parameter int               TIMEOUT      = DEF_TIMEOUT,
  parameter int               CNT_W        = DEF_CNT_W
) (
  input  logic                                 Clk,
  input  logic                                 Reset,
  input  logic                                 Vehiculo,
  input  logic                                 Termino,
  input  logic [PIN_W-1:0]                     Pin,
  input  logic                                 Pin_valido,
  output logic                                 Cerrado,
  output logic                                 Abierto,
  output logic                                 Alarma,
  output logic                                 Bloqueo,
  output logic [clog2(MAX_INTENTOS+1)-1:0]     Intentos,
  output logic [CNT_W-1:0]                     Conteo_vehiculos
);

  localparam int            IW      = clog2(MAX_INTENTOS + 1);
  localparam logic [IW-1:0] INT_MAX = IW'(MAX_INTENTOS);

  estado_t          estado_q;
  estado_t          estado_d;
  logic [IW-1:0]    intentos_q;
  logic [IW-1:0]    intentos_d;
  logic [CNT_W-1:0] conteo_q;
  logic [CNT_W-1:0] conteo_d;
  salidas_t         salidas_q;
  salidas_t         salidas_d;

  logic pin_ok;
  logic timer_clr;
  logic timer_en;
  logic expira;

  // The timer only runs while waiting for a PIN; any strobe restarts it, and
  // leaving ESPERA_PIN keeps it cleared so every new session starts at zero.
  assign pin_ok    = (Pin == PIN_CORRECTO);
  assign timer_en  = (estado_q == ESPERA_PIN) && !Pin_valido;
  assign timer_clr = !timer_en;

  temporizador_pin #(
    .TIMEOUT (TIMEOUT)
  ) u_temporizador (
    .Clk    (Clk),
    .Reset  (Reset),
    .clr    (timer_clr),
    .en     (timer_en),
    .expira (expira)
  );

  // Next-state and counter updates. A PIN strobe in ESPERA_PIN masks the
  // timer expiry, so a PIN arriving on the expiry cycle is always honoured.
  // An expiry while the vehicle is still present just restarts the timer,
  // which the sub-module does on its own.
  always_comb begin
    estado_d   = estado_q;
    intentos_d = intentos_q;
    conteo_d   = conteo_q;
    case (estado_q)
      IDLE: begin
        if (Vehiculo) begin
          estado_d = ESPERA_PIN;
        end
      end
      ESPERA_PIN: begin
        if (Pin_valido) begin
          if (pin_ok) begin
            estado_d   = ABIERTO;
            intentos_d = '0;
          end else if (intentos_q >= INT_MAX - IW'(1)) begin
            estado_d   = ALARMA;
            intentos_d = INT_MAX;
          end else begin
            intentos_d = intentos_q + IW'(1);
          end
        end else if (expira && !Vehiculo) begin
          estado_d   = IDLE;
          intentos_d = '0;
        end
      end
      ALARMA: begin
        if (Pin_valido && pin_ok) begin
          estado_d   = ABIERTO;
          intentos_d = '0;
        end
      end
      ABIERTO: begin
        if (Termino) begin
          conteo_d = conteo_q + CNT_W'(1);
          estado_d = Vehiculo ? BLOQUEO : IDLE;
        end
      end
      BLOQUEO: begin
        if (Pin_valido && pin_ok) begin
          estado_d   = IDLE;
          intentos_d = '0;
        end
      end
      default: begin
        // Unused encodings recover exactly as a reset would.
        estado_d   = IDLE;
        intentos_d = '0;
        conteo_d   = '0;
      end
    endcase
    salidas_d = decodificar(estado_d);
  end

  // Outputs are registered from the decode of the next state, which keeps
  // them glitch-free while still reflecting the state entered at this edge.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      estado_q   <= IDLE;
      intentos_q <= '0;
      conteo_q   <= '0;
      salidas_q  <= decodificar(IDLE);
    end else begin
      estado_q   <= estado_d;
      intentos_q <= intentos_d;
      conteo_q   <= conteo_d;
      salidas_q  <= salidas_d;
    end
  end

  assign Cerrado          = salidas_q.cerrado;
  assign Abierto          = salidas_q.abierto;
  assign Alarma           = salidas_q.alarma;
  assign Bloqueo          = salidas_q.bloqueo;
  assign Intentos         = intentos_q;
  assign Conteo_vehiculos = conteo_q;

endmodule

// File: tb/tb_controlador_acceso_param.sv
// tb_controlador_acceso_param
// Three instances: the default configuration, a 2-bit vehicle counter copy
// sharing the same inputs, and a 16-bit PIN / single-attempt copy with its own
// keypad inputs. Expected output vectors are queued when stimulus is driven
// and popped one cycle later when the outputs are sampled.
module tb_controlador_acceso_param;

  logic        clk = 1'b0;
  logic        reset;
  logic        vehiculo;
  logic        termino;
  logic [7:0]  pin;
  logic        pin_valido;
  logic [15:0] pin_p;
  logic        pin_valido_p;

  logic       cerrado, abierto, alarma, bloqueo;
  logic [1:0] intentos;
  logic [7:0] conteo;

  logic       cerrado_w, abierto_w, alarma_w, bloqueo_w;
  logic [1:0] intentos_w;
  logic [1:0] conteo_w;

  logic       cerrado_p, abierto_p, alarma_p, bloqueo_p;
  logic [0:0] intentos_p;
  logic [7:0] conteo_p;

  logic [13:0] exp_q[$];
  logic [1:0]  exp_w_q[$];
  logic [4:0]  exp_p_q[$];

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  controlador_acceso_param dut (
    .Clk(clk), .Reset(reset), .Vehiculo(vehiculo), .Termino(termino),
    .Pin(pin), .Pin_valido(pin_valido),
    .Cerrado(cerrado), .Abierto(abierto), .Alarma(alarma), .Bloqueo(bloqueo),
    .Intentos(intentos), .Conteo_vehiculos(conteo)
  );

  controlador_acceso_param #(.CNT_W(2)) dut_w (
    .Clk(clk), .Reset(reset), .Vehiculo(vehiculo), .Termino(termino),
    .Pin(pin), .Pin_valido(pin_valido),
    .Cerrado(cerrado_w), .Abierto(abierto_w), .Alarma(alarma_w), .Bloqueo(bloqueo_w),
    .Intentos(intentos_w), .Conteo_vehiculos(conteo_w)
  );

  controlador_acceso_param #(.PIN_W(16), .PIN_CORRECTO(16'hBEEF), .MAX_INTENTOS(1)) dut_p (
    .Clk(clk), .Reset(reset), .Vehiculo(vehiculo), .Termino(termino),
    .Pin(pin_p), .Pin_valido(pin_valido_p),
    .Cerrado(cerrado_p), .Abierto(abierto_p), .Alarma(alarma_p), .Bloqueo(bloqueo_p),
    .Intentos(intentos_p), .Conteo_vehiculos(conteo_p)
  );

  function automatic logic [13:0] ev(input logic c, input logic a, input logic al,
                                     input logic b, input logic [1:0] i, input logic [7:0] n);
    return {c, a, al, b, i, n};
  endfunction

  function automatic logic [13:0] obs();
    return {cerrado, abierto, alarma, bloqueo, intentos, conteo};
  endfunction

  function automatic logic [4:0] obs_p();
    return {cerrado_p, abierto_p, alarma_p, bloqueo_p, intentos_p};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [13:0] e;
    logic [1:0]  ew;
    logic [4:0]  ep;
    reset = 1'b1; vehiculo = 1'b0; termino = 1'b0;
    pin = 8'h00; pin_valido = 1'b0; pin_p = 16'h0000; pin_valido_p = 1'b0;
    tick();
    exp_q.push_back(ev(1, 0, 0, 0, 2'd0, 8'd0));
    exp_w_q.push_back(2'd0);
    exp_p_q.push_back(5'b1000_0);
    tick();
    reset = 1'b0;
    e = exp_q.pop_front(); total++;
    if (obs() !== e) begin bad++; $display("[TB] FAIL reset_state got=%h want=%h", obs(), e); end
    ew = exp_w_q.pop_front(); total++;
    if (conteo_w !== ew) begin bad++; $display("[TB] FAIL reset_wrap_cnt got=%h want=%h", conteo_w, ew); end
    ep = exp_p_q.pop_front(); total++;
    if (obs_p() !== ep) begin bad++; $display("[TB] FAIL reset_param got=%b want=%b", obs_p(), ep); end
  endtask

  task automatic test_nominal();
    logic [13:0] e;
    // A correct PIN in the same cycle the vehicle arrives must be ignored.
    vehiculo = 1'b1; pin = 8'h2A; pin_valido = 1'b1;
    exp_q.push_back(ev(1, 0, 0, 0, 2'd0, 8'd0));
    tick();
    pin_valido = 1'b0;
    e = exp_q.pop_front(); total++;
    if (obs() !== e) begin bad++; $display("[TB] FAIL idle_ignores_pin got=%h want=%h", obs(), e); end
    pin = 8'h2A; pin_valido = 1'b1;
    exp_q.push_back(ev(0, 1, 0, 0, 2'd0, 8'd0));
    tick();
    pin_valido = 1'b0;
    e = exp_q.pop_front(); total++;
    if (obs() !== e) begin bad++; $display("[TB] FAIL nominal_open got=%h want=%h", obs(), e); end
    vehiculo = 1'b0; termino = 1'b1;
    exp_q.push_back(ev(1, 0, 0, 0, 2'd0, 8'd1));
    tick();
    termino = 1'b0;
    e = exp_q.pop_front(); total++;
    if (obs() !== e) begin bad++; $display("[TB] FAIL nominal_pass got=%h want=%h", obs(), e); end
  endtask

  task automatic test_alarm();
    logic [13:0] e;
    logic [7:0]  malos[4];
    logic [13:0] esperado[4];
    malos    = '{8'h00, 8'h11, 8'hFF, 8'h55};
    esperado = '{ev(1, 0, 0, 0, 2'd1, 8'd1), ev(1, 0, 0, 0, 2'd2, 8'd1),
                 ev(1, 0, 1, 0, 2'd3, 8'd1), ev(1, 0, 1, 0, 2'd3, 8'd1)};
    vehiculo = 1'b1;
    tick();
    for (int k = 0; k < 4; k++) begin
      pin = malos[k]; pin_valido = 1'b1;
      exp_q.push_back(esperado[k]);
      tick();
      pin_valido = 1'b0;
      e = exp_q.pop_front(); total++;
      if (obs() !== e) begin bad++; $display("[TB] FAIL wrong_pin_%0d got=%h want=%h", k, obs(), e); end
    end
    // ALARMA has no timeout, even with the vehicle gone.
    vehiculo = 1'b0;
    exp_q.push_back(ev(1, 0, 1, 0, 2'd3, 8'd1));
    repeat (20) tick();
    e = exp_q.pop_front(); total++;
    if (obs() !== e) begin bad++; $display("[TB] FAIL alarm_no_timeout got=%h want=%h", obs(), e); end
    pin = 8'h2A; pin_valido = 1'b1;
    exp_q.push_back(ev(0, 1, 0, 0, 2'd0, 8'd1));
    tick();
    pin_valido = 1'b0;
    e = exp_q.pop_front(); total++;
    if (obs() !== e) begin bad++; $display("[TB] FAIL alarm_recover got=%h want=%h", obs(), e); end
    termino = 1'b1;
    tick();
    termino = 1'b0;
  endtask

  task automatic test_tailgate();
    logic [13:0] e;
    vehiculo = 1'b1;
    tick();
    pin = 8'h2A; pin_valido = 1'b1;
    exp_q.push_back(ev(0, 1, 0, 0, 2'd0, 8'd2));
    tick();
    pin_valido = 1'b0;
    e = exp_q.pop_front(); total++;
    if (obs() !== e) begin bad++; $display("[TB] FAIL tail_open got=%h want=%h", obs(), e); end
    pin = 8'h00; pin_valido = 1'b1;
    exp_q.push_back(ev(0, 1, 0, 0, 2'd0, 8'd2));
    tick();
    pin_valido = 1'b0;
    e = exp_q.pop_front(); total++;
    if (obs() !== e) begin bad++; $display("[TB] FAIL open_ignores_pin got=%h want=%h", obs(), e); end
    termino = 1'b1;
    exp_q.push_back(ev(1, 0, 1, 1, 2'd0, 8'd3));
    tick();
    termino = 1'b0; vehiculo = 1'b0;
    e = exp_q.pop_front(); total++;
    if (obs() !== e) begin bad++; $display("[TB] FAIL tail_block got=%h want=%h", obs(), e); end
    pin = 8'h00; pin_valido = 1'b1;
    exp_q.push_back(ev(1, 0, 1, 1, 2'd0, 8'd3));
    tick();
    pin_valido = 1'b0;
    e = exp_q.pop_front(); total++;
    if (obs() !== e) begin bad++; $display("[TB] FAIL block_wrong_pin got=%h want=%h", obs(), e); end
    pin = 8'h2A; pin_valido = 1'b1;
    exp_q.push_back(ev(1, 0, 0, 0, 2'd0, 8'd3));
    tick();
    pin_valido = 1'b0;
    e = exp_q.pop_front(); total++;
    if (obs() !== e) begin bad++; $display("[TB] FAIL block_release got=%h want=%h", obs(), e); end
  endtask

  task automatic test_timeout();
    logic [13:0] e;
    // Abandoned session: one wrong PIN, then 16 silent cycles with no vehicle.
    vehiculo = 1'b1;
    tick();
    vehiculo = 1'b0; pin = 8'h00; pin_valido = 1'b1;
    tick();
    pin_valido = 1'b0;
    exp_q.push_back(ev(1, 0, 0, 0, 2'd1, 8'd3));
    repeat (15) tick();
    e = exp_q.pop_front(); total++;
    if (obs() !== e) begin bad++; $display("[TB] FAIL before_timeout got=%h want=%h", obs(), e); end
    exp_q.push_back(ev(1, 0, 0, 0, 2'd0, 8'd3));
    tick();
    e = exp_q.pop_front(); total++;
    if (obs() !== e) begin bad++; $display("[TB] FAIL timeout_idle got=%h want=%h", obs(), e); end
    // Vehicle still present: the session survives expiry and keeps Intentos.
    vehiculo = 1'b1;
    tick();
    pin = 8'h00; pin_valido = 1'b1;
    tick();
    pin_valido = 1'b0;
    exp_q.push_back(ev(1, 0, 0, 0, 2'd1, 8'd3));
    repeat (16) tick();
    e = exp_q.pop_front(); total++;
    if (obs() !== e) begin bad++; $display("[TB] FAIL timeout_held got=%h want=%h", obs(), e); end
    // Next expiry with the vehicle gone, but the correct PIN lands on it.
    vehiculo = 1'b0;
    repeat (15) tick();
    pin = 8'h2A; pin_valido = 1'b1;
    exp_q.push_back(ev(0, 1, 0, 0, 2'd0, 8'd3));
    tick();
    pin_valido = 1'b0;
    e = exp_q.pop_front(); total++;
    if (obs() !== e) begin bad++; $display("[TB] FAIL pin_beats_timeout got=%h want=%h", obs(), e); end
    termino = 1'b1;
    exp_q.push_back(ev(1, 0, 0, 0, 2'd0, 8'd4));
    tick();
    termino = 1'b0;
    e = exp_q.pop_front(); total++;
    if (obs() !== e) begin bad++; $display("[TB] FAIL timeout_pass got=%h want=%h", obs(), e); end
  endtask

  task automatic test_reset_mid();
    logic [13:0] e;
    vehiculo = 1'b1;
    tick();
    for (int k = 0; k < 3; k++) begin
      pin = 8'(k + 1); pin_valido = 1'b1;
      tick();
    end
    pin_valido = 1'b0;
    exp_q.push_back(ev(1, 0, 1, 0, 2'd3, 8'd4));
    tick();
    e = exp_q.pop_front(); total++;
    if (obs() !== e) begin bad++; $display("[TB] FAIL mid_alarm got=%h want=%h", obs(), e); end
    reset = 1'b1; pin = 8'h2A; pin_valido = 1'b1;
    exp_q.push_back(ev(1, 0, 0, 0, 2'd0, 8'd0));
    tick();
    reset = 1'b0; pin_valido = 1'b0;
    e = exp_q.pop_front(); total++;
    if (obs() !== e) begin bad++; $display("[TB] FAIL reset_in_alarm got=%h want=%h", obs(), e); end
    tick();
    pin = 8'h2A; pin_valido = 1'b1;
    tick();
    pin_valido = 1'b0; vehiculo = 1'b0; termino = 1'b1;
    exp_q.push_back(ev(1, 0, 0, 0, 2'd0, 8'd1));
    tick();
    termino = 1'b0;
    e = exp_q.pop_front(); total++;
    if (obs() !== e) begin bad++; $display("[TB] FAIL mid_pass got=%h want=%h", obs(), e); end
    vehiculo = 1'b1;
    tick();
    pin = 8'h2A; pin_valido = 1'b1;
    exp_q.push_back(ev(0, 1, 0, 0, 2'd0, 8'd1));
    tick();
    pin_valido = 1'b0;
    e = exp_q.pop_front(); total++;
    if (obs() !== e) begin bad++; $display("[TB] FAIL mid_open got=%h want=%h", obs(), e); end
    reset = 1'b1; vehiculo = 1'b0; termino = 1'b1;
    exp_q.push_back(ev(1, 0, 0, 0, 2'd0, 8'd0));
    tick();
    reset = 1'b0; termino = 1'b0;
    e = exp_q.pop_front(); total++;
    if (obs() !== e) begin bad++; $display("[TB] FAIL reset_in_open got=%h want=%h", obs(), e); end
  endtask

  task automatic test_wrap();
    logic [13:0] e;
    logic [1:0]  ew;
    for (int k = 1; k <= 5; k++) begin
      vehiculo = 1'b1;
      tick();
      pin = 8'h2A; pin_valido = 1'b1;
      tick();
      pin_valido = 1'b0; vehiculo = 1'b0; termino = 1'b1;
      exp_q.push_back(ev(1, 0, 0, 0, 2'd0, 8'(k)));
      exp_w_q.push_back(2'(k % 4));
      tick();
      termino = 1'b0;
      e = exp_q.pop_front(); total++;
      if (obs() !== e) begin bad++; $display("[TB] FAIL pass_%0d got=%h want=%h", k, obs(), e); end
      ew = exp_w_q.pop_front(); total++;
      if (conteo_w !== ew) begin bad++; $display("[TB] FAIL wrap_%0d got=%0d want=%0d", k, conteo_w, ew); end
    end
  endtask

  task automatic test_param();
    logic [4:0] ep;
    reset = 1'b1;
    tick();
    reset = 1'b0; vehiculo = 1'b1;
    tick();
    // Low byte matches BEEF's low byte; only a full 16-bit compare rejects it.
    pin_p = 16'h00EF; pin_valido_p = 1'b1;
    exp_p_q.push_back(5'b1010_1);
    tick();
    pin_valido_p = 1'b0;
    ep = exp_p_q.pop_front(); total++;
    if (obs_p() !== ep) begin bad++; $display("[TB] FAIL param_alarm got=%b want=%b", obs_p(), ep); end
    pin_p = 16'hBEEF; pin_valido_p = 1'b1;
    exp_p_q.push_back(5'b0100_0);
    tick();
    pin_valido_p = 1'b0; vehiculo = 1'b0;
    ep = exp_p_q.pop_front(); total++;
    if (obs_p() !== ep) begin bad++; $display("[TB] FAIL param_open got=%b want=%b", obs_p(), ep); end
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_alarm();
    test_tailgate();
    test_timeout();
    test_reset_mid();
    test_wrap();
    test_param();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired got=running want=finished");
    $fatal(1, "[TB] watchdog");
  end

endmodule

// File: doc/controlador_acceso_param.md
Name: controlador_acceso_param

Overview:
Parametrised successor to the single-gate parking access controller. It senses an arriving vehicle, accepts strobed PIN entries, opens the gate on a correct PIN, and counts wrong attempts up to a configurable alarm threshold. It also detects tailgating and blocks the gate, abandons a PIN session after a timeout, and keeps a wrapping count of vehicles that have passed. It sits between the gate sensors/keypad and the gate actuator/alarm drivers.

Parameters:
PIN_W, 8, width of PIN word in bits
PIN_CORRECTO, 8'h2A, accepted PIN value (PIN_W bits)
MAX_INTENTOS, 3, wrong PINs that trigger ALARMA (>=1)
TIMEOUT, 16, Clk cycles without Pin_valido in ESPERA_PIN before the session is abandoned (>=1)
CNT_W, 8, width of vehicle counter

Ports:
Clk  input  1  system clock, rising edge
Reset  input  1  synchronous, active-high reset
Vehiculo  input  1  entry sensor, vehicle present at gate
Termino  input  1  exit sensor, vehicle has passed gate
Pin  input  PIN_W  PIN word, sampled only when Pin_valido=1
Pin_valido  input  1  one-cycle strobe, PIN entry complete
Cerrado  output  1  gate closed command
Abierto  output  1  gate open command
Alarma  output  1  alarm indicator
Bloqueo  output  1  tailgate block indicator
Intentos  output  clog2(MAX_INTENTOS+1)  current wrong-attempt count
Conteo_vehiculos  output  CNT_W  vehicles passed, wraps modulo 2^CNT_W

Behaviour:
- One clock domain (Clk). Reset is synchronous and active-high.
- Reset: state IDLE, Cerrado=1, Abierto=0, Alarma=0, Bloqueo=0, Intentos=0, Conteo_vehiculos=0, timer=0. Reset overrides all inputs in the same edge, including mid-session.
- Moore outputs: decoded from the registered state only. An input sampled at edge k changes outputs after edge k (1-cycle latency).
- IDLE: Cerrado=1, all other flags 0.
  - Vehiculo=1 -> ESPERA_PIN and clear timer.
  - Pin_valido is ignored in IDLE, including in the same cycle as Vehiculo rising.
- ESPERA_PIN: Cerrado=1. Timer increments each cycle without Pin_valido; any Pin_valido clears it.
  - Pin_valido & Pin==PIN_CORRECTO -> ABIERTO; Intentos<=0.
  - Pin_valido & wrong PIN -> Intentos+1. If the new value == MAX_INTENTOS -> ALARMA, otherwise stay.
  - Timer reaches TIMEOUT with Vehiculo=0 -> IDLE; Intentos<=0.
  - Timer reaches TIMEOUT with Vehiculo=1 -> restart timer, stay in ESPERA_PIN; Intentos unchanged.
  - Pin_valido in the same cycle the timer reaches TIMEOUT: the PIN wins and the timeout is discarded.
- ALARMA: Cerrado=1, Alarma=1.
  - Correct PIN -> ABIERTO; Intentos<=0 (Alarma drops in the next cycle).
  - Wrong PINs are ignored; Intentos saturates at MAX_INTENTOS.
  - No timeout in this state.
- ABIERTO: Abierto=1, Cerrado=0.
  - Termino=1 & Vehiculo=0 -> IDLE; Conteo_vehiculos+1.
  - Termino=1 & Vehiculo=1 (tailgate) -> BLOQUEO; Conteo_vehiculos+1.
  - Pin_valido is ignored.
- BLOQUEO: Cerrado=1, Alarma=1, Bloqueo=1.
  - Only a correct PIN exits -> IDLE; Intentos<=0.
  - Wrong PINs are ignored and do not change Intentos.
- Abierto and Cerrado are always complementary. Bloqueo=1 implies Alarma=1.
- Arithmetic:
  - Conteo_vehiculos wraps from 2^CNT_W-1 to 0.
  - Intentos never exceeds MAX_INTENTOS.
  - Timer width is clog2(TIMEOUT+1).
  - PIN compare is an exact PIN_W-bit equality.
- No illegal states: unused encodings go to IDLE with reset output values.

Decomposition:
- Package controlador_pkg holds:
  - state encodings IDLE, ESPERA_PIN, ABIERTO, ALARMA, BLOQUEO (3-bit localparams);
  - a clog2 function;
  - default parameter constants.
- Sub-module temporizador_pin: load-clear/increment/terminal-count timer parametrised by TIMEOUT, with inputs Clk, Reset, clr, en and output expira.
- FSM, attempt counter and vehicle counter stay in the top module.

Test Plan:
- Nominal pass:
  - Reset 2 cycles, then Vehiculo=1 and Pin=8'h2A with Pin_valido -> Abierto=1 one cycle after the strobe.
  - Then Termino=1, Vehiculo=0 -> Cerrado=1 and Conteo_vehiculos=1.
- Alarm and recovery:
  - Three wrong PINs (8'h00, 8'h11, 8'hFF) -> Intentos=1,2,3; Alarma=1 after the third.
  - A 4th wrong PIN -> Intentos stays 3.
  - Then 8'h2A -> Alarma=0, Abierto=1, Intentos=0.
- Tailgate:
  - In ABIERTO, Termino=1 and Vehiculo=1 together -> Bloqueo=1, Alarma=1, Cerrado=1, count+1.
  - Wrong PIN -> no change.
  - 8'h2A -> IDLE with all flags 0.
- Timeout:
  - Enter ESPERA_PIN, drop Vehiculo, no strobe for 16 cycles -> IDLE and Intentos cleared.
  - Repeat with Vehiculo held at 1 -> stays in ESPERA_PIN.
  - Strobe 8'h2A on the expiry cycle -> ABIERTO.
- Mid-operation reset:
  - Reset asserted in ALARMA and in ABIERTO -> next cycle Cerrado=1, Alarma=Bloqueo=Abierto=0, Intentos=0, Conteo_vehiculos=0.
- Wrap and parameters:
  - With CNT_W=2, 5 passes -> Conteo_vehiculos=1.
  - With PIN_W=16, PIN_CORRECTO=16'hBEEF, MAX_INTENTOS=1 -> a single wrong PIN gives Alarma=1.
